instruction_queue: RTL and testbench
====================================

// Module: instruction_queue
// PURPOSE
//   Parametrised instruction register successor: a DEPTH-entry FIFO of instruction words
//   between the memory fetch path and the decoder/control unit.
//   The head entry is split into opcode/operand fields; the following word is also exposed
//   so the decoder can consume an instruction plus an immediate word (2-word pop).
//   Lets fetch run ahead of execute. Flush discards prefetched words on jumps.
// PARAMETERS
//   WIDTH     16  instruction word width; must equal OPCODE_W + 3*OPER_W
//   OPCODE_W  7   opcode field width, taken from the top bits [WIDTH-1 -: OPCODE_W]
//   OPER_W    3   width of each operand field op0/op1/op2 (op2 in the lowest bits)
//   DEPTH     4   queue entries; power of two, >= 2
//   CNT_W     3   count width; must equal $clog2(DEPTH+1)
// PORTS
//   clock         in   1          rising-edge clock; the only clock
//   notReset      in   1          synchronous, active-low reset
//   notFlush      in   1          active-low: discard all entries on the next edge
//   notPush       in   1          active-low: write in[] at the tail
//   in            in   WIDTH      word to push
//   notPop        in   1          active-low: consume head (1 word, or 2 if popTwo)
//   popTwo        in   1          qualifies notPop: consume head and next word
//   outValid      out  1          head entry present (count >= 1)
//   outOpcode     out  OPCODE_W   head[WIDTH-1 -: OPCODE_W]
//   outOp0        out  OPER_W     head[3*OPER_W-1 -: OPER_W]
//   outOp1        out  OPER_W     head[2*OPER_W-1 -: OPER_W]
//   outOp2        out  OPER_W     head[OPER_W-1:0]
//   outNextValid  out  1          second entry present (count >= 2)
//   outNext       out  WIDTH      entry behind head (immediate word)
//   count         out  CNT_W      occupied entries, 0..DEPTH
//   full          out  1          count == DEPTH
//   empty         out  1          count == 0
//   error         out  1          sticky; set by any illegal request
// BEHAVIOUR
//   - All state updates on the rising edge of clock. Priority: notReset, then notFlush,
//     then push/pop.
//   - Reset (notReset=0 at an edge, including mid-operation): rd/wr pointers=0, count=0,
//     error=0. After that edge: empty=1, full=0, outValid=0, outNextValid=0.
//     Storage RAM need not be cleared.
//   - Field outputs are combinational from registered storage and pointers: zero latency
//     after the edge.
//   - When outValid=0: outOpcode/outOp0..2 = 0. When outNextValid=0: outNext = 0.
//   - A word pushed at edge N is visible at the head after edge N, provided the queue was
//     empty before edge N.
//   - Flush (notFlush=0, notReset=1): same pointer/count effect as reset; error cleared;
//     push/pop in the same cycle ignored.
//   - Push legal iff full=0 before the edge: writes mem[wr], wr += 1 mod DEPTH.
//   - Push while full: word dropped, error <= 1.
//     This holds even with a simultaneous pop; the pop still happens.
//   - Pop legal iff count >= 1 (popTwo=0) or count >= 2 (popTwo=1): rd += 1 or 2 mod DEPTH.
//   - Illegal pop: no pointer change, error <= 1. A simultaneous legal push still occurs.
//   - Simultaneous legal push and pop: count changes by +1-1 or +1-2.
//     A push into an empty queue cannot be popped in the same cycle (pop is illegal).
//   - Pointers are log2(DEPTH) bits and wrap naturally. count tracks occupancy separately;
//     full/empty are decoded from count.
//   - popTwo is ignored when notPop=1. error is not cleared by pops.
// TESTING
//   1 reset: hold notReset=0 one edge after random traffic -> count=0, empty=1,
//     outValid=0, outOpcode=0, error=0.
//   2 push 16'hA5C3 into empty queue -> next cycle: outOpcode=7'h52, outOp0=3'h7,
//     outOp1=3'h0, outOp2=3'h3, count=1.
//   3 push 0x1111,0x2222,0x3333,0x4444 (DEPTH=4) -> full=1.
//     Push 0x5555 -> error=1, count=4. Pop 1 -> head=0x2222, outNext=0x3333.
//   4 push/pop with popTwo across 3 pointer wraps -> FIFO order preserved.
//     Push+pop-1 in the same cycle at count=2 -> count stays 2.
//   5 count=1, notPop=0 with popTwo=1 -> no pop, error=1.
//     Then flush -> count=0, error=0.
//   6 notFlush=0 and notPush=0 in the same cycle, count=3 -> count=0 and the pushed word
//     is discarded. Reset asserted together with flush -> reset result.

Source files
------------

// File: rtl/instruction_queue.sv
// Instruction FIFO between fetch and decode. The head word is split into opcode and operand
// fields, and the word behind it is exposed as an immediate for two-word pops.
module instruction_queue #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned OPCODE_W = 7,
  parameter int unsigned OPER_W   = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                clock,
  input  logic                notReset,
  input  logic                notFlush,
  input  logic                notPush,
  input  logic [WIDTH-1:0]    in,
  input  logic                notPop,
  input  logic                popTwo,
  output logic                outValid,
  output logic [OPCODE_W-1:0] outOpcode,
  output logic [OPER_W-1:0]   outOp0,
  output logic [OPER_W-1:0]   outOp1,
  output logic [OPER_W-1:0]   outOp2,
  output logic                outNextValid,
  output logic [WIDTH-1:0]    outNext,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty,
  output logic                error
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;

  logic             push_req, pop_req, push_ok, pop_ok;
  logic [CNT_W-1:0] pop_amt;
  logic [WIDTH-1:0] head_word;
  logic [WIDTH-1:0] next_word;

  assign push_req = ~notPush;
  assign pop_req  = ~notPop;
  assign pop_amt  = popTwo ? CNT_W'(2) : CNT_W'(1);

  // Legality is judged on the occupancy before the edge, so a word pushed into an
  // empty queue can never be popped in the same cycle.
  assign push_ok = push_req && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_req && (count_q >= pop_amt);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    error_d = error_q;
    if (!notReset || !notFlush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      error_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_d = wr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_d = rd_q + PtrW'(pop_amt);
      end
      count_d = count_q + (push_ok ? CNT_W'(1) : CNT_W'(0)) - (pop_ok ? pop_amt : CNT_W'(0));
      if ((push_req && !push_ok) || (pop_req && !pop_ok)) begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    rd_q    <= rd_d;
    wr_q    <= wr_d;
    count_q <= count_d;
    error_q <= error_d;
  end

  // Storage is not reset; outputs are masked by the valid flags instead.
  always_ff @(posedge clock) begin
    if (notReset && notFlush && push_ok) begin
      mem_q[wr_q] <= in;
    end
  end

  assign outValid     = (count_q >= CNT_W'(1));
  assign outNextValid = (count_q >= CNT_W'(2));
  assign head_word    = outValid ? mem_q[rd_q] : '0;
  assign next_word    = outNextValid ? mem_q[rd_q + PtrW'(1)] : '0;

  assign outOpcode = head_word[WIDTH-1 -: OPCODE_W];
  assign outOp0    = head_word[3*OPER_W-1 -: OPER_W];
  assign outOp1    = head_word[2*OPER_W-1 -: OPER_W];
  assign outOp2    = head_word[OPER_W-1:0];
  assign outNext   = next_word;

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign error = error_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue at the default DEPTH=4 configuration.
module tb_instruction_queue;

  logic        clock = 1'b0;
  logic        notReset, notFlush, notPush, notPop, popTwo;
  logic [15:0] in;
  logic        outValid, outNextValid, full, empty, error;
  logic [6:0]  outOpcode;
  logic [2:0]  outOp0, outOp1, outOp2;
  logic [15:0] outNext;
  logic [2:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  instruction_queue dut (
    .clock        (clock),
    .notReset     (notReset),
    .notFlush     (notFlush),
    .notPush      (notPush),
    .in           (in),
    .notPop       (notPop),
    .popTwo       (popTwo),
    .outValid     (outValid),
    .outOpcode    (outOpcode),
    .outOp0       (outOp0),
    .outOp1       (outOp1),
    .outOp2       (outOp2),
    .outNextValid (outNextValid),
    .outNext      (outNext),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] head_word();
    return {outOpcode, outOp0, outOp1, outOp2};
  endfunction

  // One clock with the given controls (active-high arguments), then return to idle.
  task automatic tick(input logic rst, input logic flush, input logic push,
                      input logic [15:0] data, input logic pop, input logic two);
    notReset = ~rst;
    notFlush = ~flush;
    notPush  = ~push;
    in       = data;
    notPop   = ~pop;
    popTwo   = two;
    @(posedge clock);
    #1;
    notReset = 1'b1;
    notFlush = 1'b1;
    notPush  = 1'b1;
    notPop   = 1'b1;
    popTwo   = 1'b0;
  endtask

  task automatic push(input logic [15:0] data);
    tick(1'b0, 1'b0, 1'b1, data, 1'b0, 1'b0);
  endtask

  logic [15:0] w;

  initial begin
    notReset = 1'b0;
    notFlush = 1'b1;
    notPush  = 1'b1;
    notPop   = 1'b1;
    popTwo   = 1'b0;
    in       = '0;
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // 1: traffic, then reset
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end
    push(16'hFFFF);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_valid", 32'(outValid), 0);
    check("rst_nvalid", 32'(outNextValid), 0);
    check("rst_opcode", 32'(outOpcode), 0);
    check("rst_error", 32'(error), 0);

    // 2: field split of the head
    push(16'hA5C3);
    check("f_opcode", 32'(outOpcode), 32'h52);
    check("f_op0", 32'(outOp0), 32'h7);
    check("f_op1", 32'(outOp1), 32'h0);
    check("f_op2", 32'(outOp2), 32'h3);
    check("f_count", 32'(count), 1);
    check("f_nvalid", 32'(outNextValid), 0);
    check("f_next_zero", 32'(outNext), 0);

    // 3: fill, overflow, pop one
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 4);
    push(16'h5555);
    check("ovf_error", 32'(error), 1);
    check("ovf_count", 32'(count), 4);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("pop1_head", 32'(head_word()), 32'h2222);
    check("pop1_next", 32'(outNext), 32'h3333);
    check("pop1_count", 32'(count), 3);
    check("pop1_error_sticky", 32'(error), 1);
    // Push while full with a simultaneous pop: word dropped, pop still happens
    push(16'h6666);
    tick(1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0);
    check("fullpp_count", 32'(count), 3);
    check("fullpp_head", 32'(head_word()), 32'h3333);

    // 4: two-word pops across several pointer wraps (rd advances 2 per iteration)
    tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("flush_err_clr", 32'(error), 0);
    for (int i = 0; i < 8; i++) begin
      w = 16'h1000 + 16'(i) * 16'h0202;
      push(w);
      push(w + 16'h0101);
      check($sformatf("wrap%0d_head", i), 32'(head_word()), 32'(w));
      check($sformatf("wrap%0d_next", i), 32'(outNext), 32'(w + 16'h0101));
      tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      check($sformatf("wrap%0d_empty", i), 32'(empty), 1);
    end
    check("wrap_error", 32'(error), 0);
    push(16'hAAAA);
    push(16'hBBBB);
    tick(1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b1, 1'b0);
    check("pp_count", 32'(count), 2);
    check("pp_head", 32'(head_word()), 32'hBBBB);
    check("pp_next", 32'(outNext), 32'hCCCC);
    // Push + pop-2 at count=2 leaves only the new word
    tick(1'b0, 1'b0, 1'b1, 16'hDDDD, 1'b1, 1'b1);
    check("pp2_count", 32'(count), 1);
    check("pp2_head", 32'(head_word()), 32'hDDDD);

    // 5: illegal two-word pop at count=1, then flush
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(16'h0123);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    check("ipop_count", 32'(count), 1);
    check("ipop_error", 32'(error), 1);
    check("ipop_head", 32'(head_word()), 32'h0123);
    tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("iflush_count", 32'(count), 0);
    check("iflush_error", 32'(error), 0);
    // Illegal pop on empty with a legal push: push still occurs
    tick(1'b0, 1'b0, 1'b1, 16'h4321, 1'b1, 1'b0);
    check("ipush_count", 32'(count), 1);
    check("ipush_error", 32'(error), 1);
    check("ipush_head", 32'(head_word()), 32'h4321);

    // 6: flush beats push; reset together with flush
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(16'h0A0A);
    push(16'h0B0B);
    push(16'h0C0C);
    tick(1'b0, 1'b1, 1'b1, 16'h0D0D, 1'b0, 1'b0);
    check("fp_count", 32'(count), 0);
    check("fp_empty", 32'(empty), 1);
    push(16'h0E0E);
    check("fp_after_head", 32'(head_word()), 32'h0E0E);
    check("fp_after_count", 32'(count), 1);
    push(16'h0F0F);
    push(16'h1010);
    push(16'h2020);
    push(16'h3030);
    check("rf_pre_error", 32'(error), 1);
    tick(1'b1, 1'b1, 1'b1, 16'h4040, 1'b1, 1'b0);
    check("rf_count", 32'(count), 0);
    check("rf_error", 32'(error), 0);
    check("rf_valid", 32'(outValid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
